// File: rtl/cacheline_burst_adapter_pkg.sv
// Shared constants and FSM state type for the cacheline burst adapter.
// Line/beat geometry is derived here so every file agrees on it.
package cacheline_burst_adapter_pkg;

  localparam int HWIDTH = 256;
  localparam int BWIDTH = 64;
  localparam int BEATS = HWIDTH / BWIDTH;
  localparam int BEAT_IDX_W = $clog2(BEATS);
  localparam int LINE_OFFSET_BITS = $clog2(HWIDTH / 8);
  localparam logic [31:0] LINE_MASK =
    32'((1 << LINE_OFFSET_BITS) - 1);

  typedef enum logic [1:0] {
    IDLE,
    RBURST,
    WBURST,
    DONE
  } state_e;

endpackage

// File: rtl/cacheline_burst_adapter_beatbuf.sv
// Line register with full-line load, per-beat slice write and
// a beat-indexed read mux.
module line_beat_buffer
  import cacheline_burst_adapter_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  load_i,
  input  logic [HWIDTH-1:0]     line_i,
  input  logic                  wr_i,
  input  logic [BEAT_IDX_W-1:0] idx_i,
  input  logic [BWIDTH-1:0]     beat_i,
  output logic [HWIDTH-1:0]     line_o,
  output logic [BWIDTH-1:0]     beat_o
);

  logic [HWIDTH-1:0] line_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      line_q <= '0;
    end else if (load_i) begin
      line_q <= line_i;
    end else if (wr_i) begin
      line_q[idx_i*BWIDTH +: BWIDTH] <= beat_i;
    end
  end

  assign line_o = line_q;
  assign beat_o = line_q[idx_i*BWIDTH +: BWIDTH];

endmodule

// File: rtl/cacheline_burst_adapter.sv
// Converts one 256-bit line request into a fixed burst of 64-bit
// memory beats and returns a single-cycle line response.
module cacheline_burst_adapter
  import cacheline_burst_adapter_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic [31:0]       mem_addr,
  input  logic              mem_read,
  input  logic              mem_write,
  input  logic [HWIDTH-1:0] mem_wdata,
  output logic              mem_resp,
  output logic [HWIDTH-1:0] mem_rdata,
  output logic [31:0]       pmem_addr,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [BWIDTH-1:0] pmem_wdata,
  input  logic [BWIDTH-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  state_e                state_q, state_d;
  logic [BEAT_IDX_W-1:0] cnt_q, cnt_d;
  logic [31:0]           addr_q, addr_d;
  logic [HWIDTH-1:0]     rdata_q, rdata_d;
  logic                  buf_load, buf_wr;
  logic [HWIDTH-1:0]     buf_line;
  logic [BWIDTH-1:0]     buf_beat;
  logic                  last_beat;

  assign last_beat = pmem_resp &&
    (cnt_q == BEAT_IDX_W'(BEATS - 1));

  line_beat_buffer u_buf (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (buf_load),
    .line_i (mem_wdata),
    .wr_i   (buf_wr),
    .idx_i  (cnt_q),
    .beat_i (pmem_rdata),
    .line_o (buf_line),
    .beat_o (buf_beat)
  );

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    rdata_d  = rdata_q;
    buf_load = 1'b0;
    buf_wr   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (mem_read) begin
          addr_d  = mem_addr & ~LINE_MASK;
          cnt_d   = '0;
          state_d = RBURST;
        end else if (mem_write) begin
          addr_d   = mem_addr & ~LINE_MASK;
          cnt_d    = '0;
          buf_load = 1'b1;
          state_d  = WBURST;
        end
      end
      RBURST: begin
        if (pmem_resp) begin
          buf_wr = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (last_beat) begin
            // Publish the line with the final beat merged in.
            rdata_d = buf_line;
            rdata_d[cnt_q*BWIDTH +: BWIDTH] = pmem_rdata;
            state_d = DONE;
          end
        end
      end
      WBURST: begin
        if (pmem_resp) begin
          cnt_d = cnt_q + 1'b1;
          if (last_beat) state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
    end
  end

  assign mem_resp   = (state_q == DONE);
  assign mem_rdata  = rdata_q;
  assign pmem_addr  = addr_q;
  assign pmem_read  = (state_q == RBURST);
  assign pmem_write = (state_q == WBURST);
  assign pmem_wdata = pmem_write ? buf_beat : '0;

endmodule

// File: tb/tb_cacheline_burst_adapter.sv
// Self-checking bench: the bench plays physical memory and requester,
// predicting each beat and line from address/data it generated itself.
module tb_cacheline_burst_adapter;
  import cacheline_burst_adapter_pkg::*;

  logic              clk;
  logic              rst_n;
  logic [31:0]       mem_addr;
  logic              mem_read;
  logic              mem_write;
  logic [HWIDTH-1:0] mem_wdata;
  logic              mem_resp;
  logic [HWIDTH-1:0] mem_rdata;
  logic [31:0]       pmem_addr;
  logic              pmem_read;
  logic              pmem_write;
  logic [BWIDTH-1:0] pmem_wdata;
  logic [BWIDTH-1:0] pmem_rdata;
  logic              pmem_resp;

  int checks = 0;
  int failures = 0;
  logic [HWIDTH-1:0] last_rd;

  cacheline_burst_adapter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mem_addr   (mem_addr),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_wdata  (mem_wdata),
    .mem_resp   (mem_resp),
    .mem_rdata  (mem_rdata),
    .pmem_addr  (pmem_addr),
    .pmem_read  (pmem_read),
    .pmem_write (pmem_write),
    .pmem_wdata (pmem_wdata),
    .pmem_rdata (pmem_rdata),
    .pmem_resp  (pmem_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [HWIDTH-1:0] obs,
                     input logic [HWIDTH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [HWIDTH-1:0] rand_line();
    logic [HWIDTH-1:0] l;
    for (int i = 0; i < HWIDTH / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic run_read(input logic [31:0] a,
                          input logic [HWIDTH-1:0] line,
                          input int gmin, input int gmax,
                          input logic both);
    logic [31:0] exp_a;
    int g;
    exp_a = a & 32'hffff_ffe0;
    mem_addr = a;
    mem_read = 1'b1;
    mem_write = both;
    mem_wdata = rand_line();
    @(negedge clk);
    for (int b = 0; b < BEATS; b++) begin
      g = $urandom_range(gmax, gmin);
      for (int k = 0; k <= g; k++) begin
        chk("rd_pread", pmem_read, 1);
        chk("rd_paddr", pmem_addr, exp_a);
        chk("rd_pwrite", pmem_write, 0);
        chk("rd_mresp", mem_resp, 0);
        mem_addr = $urandom;
        pmem_resp = (k == g);
        pmem_rdata = (k == g) ? line[b*BWIDTH +: BWIDTH]
                              : {$urandom, $urandom};
        @(negedge clk);
      end
    end
    pmem_resp = 1'b0;
    chk("rd_resp", mem_resp, 1);
    chk("rd_rdata", mem_rdata, line);
    chk("rd_pread_done", pmem_read, 0);
    chk("rd_pwrite_done", pmem_write, 0);
    mem_read = 1'b0;
    mem_write = 1'b0;
    last_rd = line;
    @(negedge clk);
    chk("rd_resp_once", mem_resp, 0);
    chk("rd_pread_idle", pmem_read, 0);
  endtask

  task automatic run_write(input logic [31:0] a,
                           input logic [HWIDTH-1:0] line,
                           input int gmin, input int gmax);
    logic [31:0] exp_a;
    int g;
    exp_a = a & 32'hffff_ffe0;
    mem_addr = a;
    mem_write = 1'b1;
    mem_wdata = line;
    @(negedge clk);
    for (int b = 0; b < BEATS; b++) begin
      g = $urandom_range(gmax, gmin);
      for (int k = 0; k <= g; k++) begin
        chk("wr_pwrite", pmem_write, 1);
        chk("wr_pread", pmem_read, 0);
        chk("wr_paddr", pmem_addr, exp_a);
        chk("wr_wdata", pmem_wdata, line[b*BWIDTH +: BWIDTH]);
        chk("wr_mresp", mem_resp, 0);
        chk("wr_rdata_hold", mem_rdata, last_rd);
        mem_addr = $urandom;
        mem_wdata = rand_line();
        pmem_resp = (k == g);
        pmem_rdata = {$urandom, $urandom};
        @(negedge clk);
      end
    end
    pmem_resp = 1'b0;
    chk("wr_resp", mem_resp, 1);
    chk("wr_pwrite_done", pmem_write, 0);
    mem_write = 1'b0;
    @(negedge clk);
    chk("wr_resp_once", mem_resp, 0);
    chk("wr_pwrite_idle", pmem_write, 0);
  endtask

  initial begin
    rst_n = 1'b1;
    mem_addr = '0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_wdata = '0;
    pmem_rdata = '0;
    pmem_resp = 1'b0;
    last_rd = '0;
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_mresp", mem_resp, 0);
    chk("rst_rdata", mem_rdata, 0);
    chk("rst_pread", pmem_read, 0);
    chk("rst_pwrite", pmem_write, 0);
    chk("rst_paddr", pmem_addr, 0);
    chk("rst_pwdata", pmem_wdata, 0);
    rst_n = 1'b1;
    @(negedge clk);

    run_read(32'h0000_1234,
             {{16{4'h4}}, {16{4'h3}}, {16{4'h2}}, {16{4'h1}}},
             0, 0, 1'b0);
    run_write(32'h0000_0040, rand_line(), 2, 2);
    run_read($urandom, rand_line(), 0, 1, 1'b0);
    run_write($urandom, rand_line(), 0, 1);
    run_read($urandom, rand_line(), 0, 2, 1'b1);

    for (int i = 0; i < 3; i++) begin
      pmem_resp = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      @(negedge clk);
      chk("idle_mresp", mem_resp, 0);
      chk("idle_pread", pmem_read, 0);
      chk("idle_pwrite", pmem_write, 0);
    end
    pmem_resp = 1'b0;

    mem_addr = 32'h0000_2000;
    mem_read = 1'b1;
    @(negedge clk);
    for (int b = 0; b < 2; b++) begin
      pmem_resp = 1'b1;
      pmem_rdata = {$urandom, $urandom};
      @(negedge clk);
    end
    pmem_resp = 1'b0;
    mem_read = 1'b0;
    chk("abort_pread_pre", pmem_read, 1);
    rst_n = 1'b0;
    #1;
    chk("abort_mresp", mem_resp, 0);
    chk("abort_rdata", mem_rdata, 0);
    chk("abort_pread", pmem_read, 0);
    chk("abort_pwrite", pmem_write, 0);
    chk("abort_paddr", pmem_addr, 0);
    chk("abort_pwdata", pmem_wdata, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    last_rd = '0;
    @(negedge clk);
    chk("post_rst_mresp", mem_resp, 0);
    chk("post_rst_pread", pmem_read, 0);
    run_read(32'h0000_0100, rand_line(), 0, 1, 1'b0);

    for (int i = 0; i < 12; i++) begin
      if ($urandom_range(1, 0) == 1)
        run_read($urandom, rand_line(), 0, 3, 1'($urandom_range(1, 0)));
      else
        run_write($urandom, rand_line(), 0, 3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
